// File: rtl/pipe_control_if.sv
// Control-unit bus between the ID decoder/register file and the datapath stage registers.
// The decoder/datapath side drives the master modport; the control unit takes the slave modport.
`timescale 1ns/1ps
interface pipe_control_if #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int EXT_W   = 3
);
    logic [6:0]         OP;
    logic               id_valid;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [REG_AW-1:0]  rd;
    logic               branch_taken;
    logic               dm_ready;

    logic [EXT_W-1:0]   id_ExtenSel;
    logic               stall_if;
    logic               flush_id;
    logic [1:0]         pc_sel;
    logic               ex_ALUSrc;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic               mem_DM_en;
    logic               mem_DM_write;
    logic               wb_RegWrite;
    logic [1:0]         wb_MemtoReg;
    logic [REG_AW-1:0]  wb_rd;
    logic               dm_timeout;

    modport master (
        output OP, id_valid, rs1, rs2, rd, branch_taken, dm_ready,
        input  id_ExtenSel, stall_if, flush_id, pc_sel, ex_ALUSrc, ex_ALUOp,
               mem_DM_en, mem_DM_write, wb_RegWrite, wb_MemtoReg, wb_rd, dm_timeout
    );

    modport slave (
        input  OP, id_valid, rs1, rs2, rd, branch_taken, dm_ready,
        output id_ExtenSel, stall_if, flush_id, pc_sel, ex_ALUSrc, ex_ALUOp,
               mem_DM_en, mem_DM_write, wb_RegWrite, wb_MemtoReg, wb_rd, dm_timeout
    );
endinterface

// File: rtl/pipe_control.sv
// Pipelined control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundles,
// load-use stall, branch/jump flush and data-memory freeze with timeout release.
`timescale 1ns/1ps
module pipe_control #(
    parameter int REG_AW     = 5,
    parameter int ALUOP_W    = 2,
    parameter int EXT_W      = 3,
    parameter int DM_TIMEOUT = 15
) (
    input logic           clk,
    input logic           rst,
    pipe_control_if.slave bus
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam int         CNT_W = $clog2(DM_TIMEOUT + 1);

    typedef struct packed {
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               dm_en;
        logic               dm_write;
        logic               regwrite;
        logic [1:0]         memtoreg;
        logic               branch;
        logic               jump;
        logic [REG_AW-1:0]  rd;
    } ex_ctl_t;

    typedef struct packed {
        logic              dm_en;
        logic              dm_write;
        logic              regwrite;
        logic [1:0]        memtoreg;
        logic [REG_AW-1:0] rd;
    } mem_ctl_t;

    typedef struct packed {
        logic              regwrite;
        logic [1:0]        memtoreg;
        logic [REG_AW-1:0] rd;
    } wb_ctl_t;

    ex_ctl_t          id_ctl, ex_q;
    mem_ctl_t         mem_d, mem_q;
    wb_ctl_t          wb_d, wb_q;
    logic [EXT_W-1:0] id_ext;
    logic [CNT_W-1:0] wait_cnt;
    logic             dm_timeout_q;

    logic mem_wait, timed_out, frozen, redirect;
    logic reads_rs1, reads_rs2, ex_load, rs_hit, load_use;

    always_comb begin
        id_ctl = '0;
        id_ext = '0;
        if (bus.id_valid) begin
            case (bus.OP)
                OP_R: begin
                    id_ctl.regwrite = 1'b1;
                    id_ctl.memtoreg = 2'b01;
                end
                OP_I: begin
                    id_ctl.alusrc   = 1'b1;
                    id_ctl.regwrite = 1'b1;
                    id_ctl.memtoreg = 2'b01;
                end
                OP_LW: begin
                    id_ctl.dm_en    = 1'b1;
                    id_ctl.alusrc   = 1'b1;
                    id_ctl.aluop    = ALUOP_W'(1);
                    id_ctl.regwrite = 1'b1;
                    id_ctl.memtoreg = 2'b00;
                end
                OP_S: begin
                    id_ctl.dm_en    = 1'b1;
                    id_ctl.dm_write = 1'b1;
                    id_ctl.alusrc   = 1'b1;
                    id_ctl.aluop    = ALUOP_W'(1);
                    id_ext          = EXT_W'(1);
                end
                OP_B: begin
                    id_ctl.branch = 1'b1;
                    id_ctl.aluop  = ALUOP_W'(2);
                    id_ext        = EXT_W'(2);
                end
                OP_U: begin
                    id_ctl.regwrite = 1'b1;
                    id_ctl.memtoreg = 2'b10;
                    id_ext          = EXT_W'(3);
                end
                OP_J: begin
                    id_ctl.jump     = 1'b1;
                    id_ctl.regwrite = 1'b1;
                    id_ctl.memtoreg = 2'b11;
                    id_ext          = EXT_W'(4);
                end
                default: ;
            endcase
        end
        // Destination only travels with instructions that write it, so ex_rd of a store/branch never hazards.
        if (id_ctl.regwrite) id_ctl.rd = bus.rd;
    end

    always_comb begin
        mem_d.dm_en    = ex_q.dm_en;
        mem_d.dm_write = ex_q.dm_write;
        mem_d.regwrite = ex_q.regwrite;
        mem_d.memtoreg = ex_q.memtoreg;
        mem_d.rd       = ex_q.rd;
        wb_d.regwrite  = mem_q.regwrite;
        wb_d.memtoreg  = mem_q.memtoreg;
        wb_d.rd        = mem_q.rd;
    end

    // Priority: memory freeze, then EX redirect, then load-use stall.
    assign mem_wait  = mem_q.dm_en && !bus.dm_ready;
    assign timed_out = (wait_cnt == CNT_W'(DM_TIMEOUT));
    assign frozen    = mem_wait && !timed_out;
    assign redirect  = !frozen && (ex_q.jump || (ex_q.branch && bus.branch_taken));

    assign reads_rs1 = bus.OP inside {OP_R, OP_I, OP_LW, OP_S, OP_B};
    assign reads_rs2 = bus.OP inside {OP_R, OP_S, OP_B};
    assign ex_load   = ex_q.dm_en && !ex_q.dm_write && (ex_q.rd != '0);
    assign rs_hit    = (reads_rs1 && (ex_q.rd == bus.rs1)) || (reads_rs2 && (ex_q.rd == bus.rs2));
    assign load_use  = !frozen && !redirect && ex_load && bus.id_valid && rs_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            wait_cnt     <= '0;
            dm_timeout_q <= 1'b0;
        end else if (frozen) begin
            wb_q     <= '0;
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            ex_q     <= (redirect || load_use) ? '0 : id_ctl;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            wait_cnt <= '0;
            // Unfrozen while memory still busy means the timeout forced this release.
            if (mem_wait) dm_timeout_q <= 1'b1;
        end
    end

    assign bus.id_ExtenSel  = id_ext;
    assign bus.stall_if     = frozen || load_use;
    assign bus.flush_id     = redirect;
    assign bus.pc_sel       = !redirect ? 2'b00 : (ex_q.jump ? 2'b10 : 2'b01);
    assign bus.ex_ALUSrc    = ex_q.alusrc;
    assign bus.ex_ALUOp     = ex_q.aluop;
    assign bus.mem_DM_en    = mem_q.dm_en;
    assign bus.mem_DM_write = mem_q.dm_write;
    assign bus.wb_RegWrite  = wb_q.regwrite && (wb_q.rd != '0);
    assign bus.wb_MemtoReg  = wb_q.memtoreg;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.dm_timeout   = dm_timeout_q;
endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: instruction-level pipeline model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with mid-run resets.
`timescale 1ns/1ps
module tb_pipe_control;
    localparam int RAW = 5, AW = 2, EW = 3, TMO = 15;
    localparam logic [6:0] R = 7'h33, I = 7'h13, LW = 7'h03, S = 7'h23, B = 7'h63, U = 7'h37, J = 7'h6F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_control_if #(.REG_AW(RAW), .ALUOP_W(AW), .EXT_W(EW)) bus();
    pipe_control #(.REG_AW(RAW), .ALUOP_W(AW), .EXT_W(EW), .DM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef enum int {K_NONE, K_R, K_I, K_LW, K_S, K_B, K_U, K_J} kind_e;
    typedef struct { kind_e k; logic [4:0] rd; } ins_t;

    ins_t st[3];          // 0 = EX, 1 = MEM, 2 = WB
    int   waited = 0;
    bit   tmo_flag = 0;
    bit   m_stall = 0;

    function automatic kind_e kind_of(input logic [6:0] op, input logic v);
        if (v !== 1'b1) return K_NONE;
        case (op)
            R: return K_R;   I: return K_I;   LW: return K_LW; S: return K_S;
            B: return K_B;   U: return K_U;   J: return K_J;
            default: return K_NONE;
        endcase
    endfunction
    function automatic bit writes(input kind_e k); return k inside {K_R, K_I, K_LW, K_U, K_J}; endfunction
    function automatic bit reads1(input kind_e k); return k inside {K_R, K_I, K_LW, K_S, K_B}; endfunction
    function automatic bit reads2(input kind_e k); return k inside {K_R, K_S, K_B}; endfunction
    function automatic bit is_mem(input kind_e k); return k inside {K_LW, K_S}; endfunction
    function automatic int ext_of(input kind_e k);
        case (k) K_S: return 1; K_B: return 2; K_U: return 3; K_J: return 4; default: return 0; endcase
    endfunction
    function automatic int src_of(input kind_e k);
        case (k) K_R, K_I: return 1; K_U: return 2; K_J: return 3; default: return 0; endcase
    endfunction
    function automatic int aluop_of(input kind_e k);
        case (k) K_LW, K_S: return 1; K_B: return 2; default: return 0; endcase
    endfunction

    always @(negedge clk) begin
        ins_t id;
        bit busy, freeze, redir, lu;
        int e_pc;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin st[i].k = K_NONE; st[i].rd = '0; end
            waited = 0;
            tmo_flag = 0;
        end
        id.k  = kind_of(bus.OP, bus.id_valid);
        id.rd = writes(id.k) ? bus.rd : 5'd0;
        busy   = is_mem(st[1].k) && (bus.dm_ready == 1'b0);
        freeze = busy && (waited < TMO);
        redir  = !freeze && (st[0].k == K_J || (st[0].k == K_B && bus.branch_taken == 1'b1));
        lu     = !freeze && !redir && st[0].k == K_LW && st[0].rd != 0 && id.k != K_NONE &&
                 ((reads1(id.k) && st[0].rd == bus.rs1) || (reads2(id.k) && st[0].rd == bus.rs2));
        e_pc   = !redir ? 0 : (st[0].k == K_J ? 2 : 1);

        chk("m_ExtenSel", bus.id_ExtenSel, ext_of(id.k));
        chk("m_stall_if", bus.stall_if, freeze || lu);
        chk("m_flush_id", bus.flush_id, redir);
        chk("m_pc_sel", bus.pc_sel, e_pc);
        chk("m_ex_ALUSrc", bus.ex_ALUSrc, st[0].k inside {K_I, K_LW, K_S});
        chk("m_ex_ALUOp", bus.ex_ALUOp, aluop_of(st[0].k));
        chk("m_mem_DM_en", bus.mem_DM_en, is_mem(st[1].k));
        chk("m_mem_DM_write", bus.mem_DM_write, st[1].k == K_S);
        chk("m_wb_RegWrite", bus.wb_RegWrite, writes(st[2].k) && st[2].rd != 0);
        chk("m_wb_MemtoReg", bus.wb_MemtoReg, src_of(st[2].k));
        chk("m_wb_rd", bus.wb_rd, st[2].rd);
        chk("m_dm_timeout", bus.dm_timeout, tmo_flag);
        m_stall = freeze || lu;

        if (rst) begin
            if (freeze) begin
                st[2].k = K_NONE; st[2].rd = '0;
                waited++;
            end else begin
                if (busy) tmo_flag = 1;
                waited = 0;
                st[2] = st[1];
                st[1] = st[0];
                if (redir || lu) begin st[0].k = K_NONE; st[0].rd = '0; end
                else st[0] = id;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] ops [9] = '{R, I, LW, S, B, U, J, 7'h7F, 7'h00};

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic drv(input logic [6:0] op, input logic v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        bus.OP = op; bus.id_valid = v; bus.rs1 = a; bus.rs2 = b; bus.rd = d;
    endtask
    task automatic rnd_id();
        drv(ops[$urandom_range(0, 8)], $urandom_range(0, 9) != 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    endtask

    initial begin
        int lowrun;
        drv(R, 1'b0, 0, 0, 0);
        bus.branch_taken = 1'b0;
        bus.dm_ready = 1'b1;
        #1 rst = 1'b0;

        // reset held with random inputs
        repeat (3) begin
            rnd_id();
            bus.branch_taken = 1'($urandom_range(0, 1));
            bus.dm_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rst_stall_if", bus.stall_if, 0);
            chk("rst_pc_sel", bus.pc_sel, 0);
            chk("rst_wb_RegWrite", bus.wb_RegWrite, 0);
            chk("rst_mem_DM_en", bus.mem_DM_en, 0);
            chk("rst_dm_timeout", bus.dm_timeout, 0);
            tick();
        end

        // R rd=3 reaches WB exactly three edges later
        rst = 1'b1; bus.dm_ready = 1'b1; bus.branch_taken = 1'b0;
        drv(R, 1, 1, 2, 3); tick();
        drv(R, 0, 0, 0, 0); tick();
        #1 chk("r_wb_early", bus.wb_RegWrite, 0);
        tick();
        #1 chk("r_wb_we", bus.wb_RegWrite, 1);
        chk("r_wb_src", bus.wb_MemtoReg, 1);
        chk("r_wb_rd", bus.wb_rd, 3);

        // load-use: LW rd=5 then ADD rs1=5
        drv(LW, 1, 1, 0, 5); tick();
        drv(R, 1, 5, 2, 6);
        #1 chk("lu_stall", bus.stall_if, 1);
        chk("lu_flush", bus.flush_id, 0);
        tick();
        #1 chk("lu_stall_once", bus.stall_if, 0);
        chk("lu_mem_en", bus.mem_DM_en, 1);
        tick();
        drv(R, 0, 0, 0, 0);
        #1 chk("lu_ld_wb_rd", bus.wb_rd, 5);
        chk("lu_ld_wb_src", bus.wb_MemtoReg, 0);
        tick();
        #1 chk("lu_bubble_wb", bus.wb_RegWrite, 0);
        tick();
        #1 chk("lu_add_wb_rd", bus.wb_rd, 6);
        chk("lu_add_wb_we", bus.wb_RegWrite, 1);

        // load-use on x0 never stalls
        drv(LW, 1, 1, 0, 0); tick();
        drv(R, 1, 0, 0, 6);
        #1 chk("lu_rd0_stall", bus.stall_if, 0);
        tick(); drv(R, 0, 0, 0, 0); tick(); tick();

        // taken branch squashes the younger instruction
        drv(B, 1, 1, 2, 9);
        #1 chk("br_ext", bus.id_ExtenSel, 2);
        tick();
        drv(R, 1, 3, 4, 7); bus.branch_taken = 1'b1;
        #1 chk("br_pc", bus.pc_sel, 1);
        chk("br_flush", bus.flush_id, 1);
        chk("br_stall", bus.stall_if, 0);
        tick();
        drv(R, 0, 0, 0, 0); bus.branch_taken = 1'b0;
        #1 chk("br_pc_after", bus.pc_sel, 0);
        tick(); tick();
        #1 chk("br_squash_we", bus.wb_RegWrite, 0);

        // not-taken branch
        drv(B, 1, 1, 2, 0); tick();
        drv(R, 1, 3, 4, 7); bus.branch_taken = 1'b0;
        #1 chk("nt_flush", bus.flush_id, 0);
        chk("nt_pc", bus.pc_sel, 0);
        tick(); drv(R, 0, 0, 0, 0); tick(); tick();
        #1 chk("nt_wb_rd", bus.wb_rd, 7);
        chk("nt_wb_we", bus.wb_RegWrite, 1);

        // jump
        drv(J, 1, 0, 0, 1);
        #1 chk("j_ext", bus.id_ExtenSel, 4);
        tick(); drv(R, 0, 0, 0, 0);
        #1 chk("j_pc", bus.pc_sel, 2);
        chk("j_flush", bus.flush_id, 1);
        tick(); tick();
        #1 chk("j_wb_src", bus.wb_MemtoReg, 3);
        chk("j_wb_we", bus.wb_RegWrite, 1);
        chk("j_wb_rd", bus.wb_rd, 1);

        // store waits four cycles on memory
        drv(S, 1, 1, 2, 0); tick();
        drv(R, 0, 0, 0, 0); tick();
        bus.dm_ready = 1'b0;
        repeat (4) begin
            #1 chk("mw_stall", bus.stall_if, 1);
            chk("mw_dm_en", bus.mem_DM_en, 1);
            chk("mw_wb_we", bus.wb_RegWrite, 0);
            tick();
        end
        bus.dm_ready = 1'b1;
        #1 chk("mw_release", bus.stall_if, 0);
        chk("mw_tmo", bus.dm_timeout, 0);
        tick();
        #1 chk("mw_dm_en_after", bus.mem_DM_en, 0);

        // load with memory never ready: forced release after 15 frozen cycles
        drv(LW, 1, 1, 0, 4); tick();
        drv(R, 0, 0, 0, 0); tick();
        bus.dm_ready = 1'b0;
        repeat (15) begin
            #1 chk("to_stall", bus.stall_if, 1);
            tick();
        end
        #1 chk("to_release", bus.stall_if, 0);
        chk("to_flag_before", bus.dm_timeout, 0);
        tick();
        #1 chk("to_flag", bus.dm_timeout, 1);
        chk("to_wb_rd", bus.wb_rd, 4);
        bus.dm_ready = 1'b1;
        repeat (3) tick();
        #1 chk("to_sticky", bus.dm_timeout, 1);

        // freeze while EX holds a taken branch
        drv(LW, 1, 1, 0, 8); tick();
        drv(B, 1, 2, 3, 0); tick();
        drv(R, 0, 0, 0, 0); bus.dm_ready = 1'b0; bus.branch_taken = 1'b1;
        repeat (2) begin
            #1 chk("fb_pc", bus.pc_sel, 0);
            chk("fb_stall", bus.stall_if, 1);
            tick();
        end
        bus.dm_ready = 1'b1;
        #1 chk("fb_pc_rel", bus.pc_sel, 1);
        chk("fb_flush", bus.flush_id, 1);
        tick();
        bus.branch_taken = 1'b0;
        #1 chk("fb_pc_after", bus.pc_sel, 0);

        // asynchronous reset in the middle of a freeze
        drv(S, 1, 1, 2, 0); tick();
        drv(R, 0, 0, 0, 0); tick();
        bus.dm_ready = 1'b0; tick(); tick();
        #2 rst = 1'b0;
        #1 chk("ar_stall", bus.stall_if, 0);
        chk("ar_dm_en", bus.mem_DM_en, 0);
        chk("ar_tmo", bus.dm_timeout, 0);
        tick();
        rst = 1'b1; bus.dm_ready = 1'b1;

        // randomized traffic; ID is held whenever the model says IF/ID is stalled
        lowrun = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!m_stall) rnd_id();
            bus.branch_taken = 1'($urandom_range(0, 1));
            if (lowrun > 0) begin
                bus.dm_ready = 1'b0;
                lowrun--;
            end else if ($urandom_range(0, 24) == 0) begin
                lowrun = $urandom_range(1, 20);
                bus.dm_ready = 1'b0;
            end else begin
                bus.dm_ready = $urandom_range(0, 3) != 0;
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
